// File: rtl/biquad_sequencer_if.sv
// Sample, result and configuration signals shared between the biquad sequencer
// and its surroundings; the sequencer takes the slave side.
interface biquad_sequencer_if #(
  parameter int CH_W = 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic [CH_W-1:0]        in_ch;
  logic signed [15:0]     in_sample;
  logic                   out_valid;
  logic [CH_W-1:0]        out_ch;
  logic signed [15:0]     out_sample;
  logic                   out_sat;
  logic                   cfg_we;
  logic [2:0]             cfg_addr;
  logic signed [31:0]     cfg_data;
  logic                   busy;

  modport master (
    output in_valid, in_ch, in_sample, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_ch, out_sample, out_sat, busy
  );

  modport slave (
    input  in_valid, in_ch, in_sample, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_ch, out_sample, out_sat, busy
  );
endinterface

// File: rtl/biquad_sequencer.sv
// Multi-channel biquad IIR section evaluated on one shared multiplier, five taps per
// sample, with per-channel delay state and a shadow/active coefficient bank.
module biquad_sequencer #(
  parameter int CHANNELS = 2,
  parameter int FRAC     = 10,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  biquad_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_e;

  localparam logic signed [31:0] COEF_ONE  = 32'sd1 <<< FRAC;
  localparam logic signed [51:0] ROUND_ADD = 52'sd1 <<< (FRAC - 1);
  localparam logic signed [51:0] SAT_MAX   = 52'sd32767;
  localparam logic signed [51:0] SAT_MIN   = -52'sd32768;
  localparam logic [CH_W:0]      CH_LIMIT  = (CH_W + 1)'(CHANNELS);

  state_e                state_q, state_d;
  logic [2:0]            tap_q, tap_d;
  logic signed [51:0]    acc_q, acc_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  ch_ok_q, ch_ok_d;
  logic signed [15:0]    x0_q, x0_d;
  logic signed [31:0]    coef_sh_q [5];
  logic signed [31:0]    coef_sh_d [5];
  logic signed [31:0]    coef_act_q [5];
  logic signed [31:0]    coef_act_d [5];
  logic signed [15:0]    x1_q [CHANNELS];
  logic signed [15:0]    x1_d [CHANNELS];
  logic signed [15:0]    x2_q [CHANNELS];
  logic signed [15:0]    x2_d [CHANNELS];
  logic signed [15:0]    y1_q [CHANNELS];
  logic signed [15:0]    y1_d [CHANNELS];
  logic signed [15:0]    y2_q [CHANNELS];
  logic signed [15:0]    y2_d [CHANNELS];
  logic                  clear_pending_q, clear_pending_d;
  logic                  out_valid_q, out_valid_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic signed [15:0]    out_sample_q, out_sample_d;
  logic                  out_sat_q, out_sat_d;

  logic                  in_ready;
  logic [CH_W-1:0]       ch_sel;
  logic signed [15:0]    mul_a;
  logic signed [31:0]    mul_b;
  logic signed [47:0]    product;
  logic signed [51:0]    acc_round;
  logic signed [51:0]    acc_shift;
  logic signed [15:0]    sat_val;
  logic                  clipped;

  assign in_ready       = (state_q == IDLE) && !clear_pending_q;
  assign bus.in_ready   = in_ready;
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.out_sample = out_sample_q;
  assign bus.out_sat    = out_sat_q;

  // Out-of-range channels still run the taps but read channel 0 to stay in bounds.
  assign ch_sel = ch_ok_q ? ch_q : '0;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (tap_q)
      3'd0: begin mul_a = x0_q;         mul_b = coef_act_q[0]; end
      3'd1: begin mul_a = x1_q[ch_sel]; mul_b = coef_act_q[1]; end
      3'd2: begin mul_a = x2_q[ch_sel]; mul_b = coef_act_q[2]; end
      3'd3: begin mul_a = y1_q[ch_sel]; mul_b = coef_act_q[3]; end
      3'd4: begin mul_a = y2_q[ch_sel]; mul_b = coef_act_q[4]; end
      default: ;
    endcase
  end

  assign product = 48'(mul_a) * 48'(mul_b);

  always_comb begin
    acc_round = acc_q + ROUND_ADD;
    acc_shift = acc_round >>> FRAC;
    sat_val   = acc_shift[15:0];
    clipped   = 1'b0;
    if (acc_shift > SAT_MAX) begin
      sat_val = 16'sh7fff;
      clipped = 1'b1;
    end else if (acc_shift < SAT_MIN) begin
      sat_val = -16'sh8000;
      clipped = 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    tap_d           = tap_q;
    acc_d           = acc_q;
    ch_d            = ch_q;
    ch_ok_d         = ch_ok_q;
    x0_d            = x0_q;
    coef_sh_d       = coef_sh_q;
    coef_act_d      = coef_act_q;
    x1_d            = x1_q;
    x2_d            = x2_q;
    y1_d            = y1_q;
    y2_d            = y2_q;
    clear_pending_d = clear_pending_q;
    out_valid_d     = 1'b0;
    out_ch_d        = out_ch_q;
    out_sample_d    = out_sample_q;
    out_sat_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_pending_q) begin
          for (int c = 0; c < CHANNELS; c++) begin
            x1_d[c] = '0;
            x2_d[c] = '0;
            y1_d[c] = '0;
            y2_d[c] = '0;
          end
          clear_pending_d = 1'b0;
        end else if (bus.in_valid) begin
          ch_d       = bus.in_ch;
          ch_ok_d    = ({1'b0, bus.in_ch} < CH_LIMIT);
          x0_d       = bus.in_sample;
          coef_act_d = coef_sh_q;
          acc_d      = '0;
          tap_d      = '0;
          state_d    = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{4{product[47]}}, product};
        if (tap_q == 3'd4) begin
          state_d = WRITE;
        end else begin
          tap_d = tap_q + 3'd1;
        end
      end
      WRITE: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_ch_d    = ch_q;
        if (ch_ok_q) begin
          out_sample_d = sat_val;
          out_sat_d    = clipped;
          x2_d[ch_sel] = x1_q[ch_sel];
          x1_d[ch_sel] = x0_q;
          y2_d[ch_sel] = y1_q[ch_sel];
          y1_d[ch_sel] = sat_val;
        end else begin
          out_sample_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear written while one is being serviced must survive, so it comes last.
    if (bus.cfg_we) begin
      for (int i = 0; i < 5; i++) begin
        if (bus.cfg_addr == 3'(i)) coef_sh_d[i] = bus.cfg_data;
      end
      if (bus.cfg_addr == 3'd7) clear_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      tap_q           <= '0;
      acc_q           <= '0;
      ch_q            <= '0;
      ch_ok_q         <= 1'b0;
      x0_q            <= '0;
      clear_pending_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_ch_q        <= '0;
      out_sample_q    <= '0;
      out_sat_q       <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        coef_sh_q[i]  <= (i == 0) ? COEF_ONE : 32'sd0;
        coef_act_q[i] <= (i == 0) ? COEF_ONE : 32'sd0;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else begin
      state_q         <= state_d;
      tap_q           <= tap_d;
      acc_q           <= acc_d;
      ch_q            <= ch_d;
      ch_ok_q         <= ch_ok_d;
      x0_q            <= x0_d;
      clear_pending_q <= clear_pending_d;
      out_valid_q     <= out_valid_d;
      out_ch_q        <= out_ch_d;
      out_sample_q    <= out_sample_d;
      out_sat_q       <= out_sat_d;
      coef_sh_q       <= coef_sh_d;
      coef_act_q      <= coef_act_d;
      x1_q            <= x1_d;
      x2_q            <= x2_d;
      y1_q            <= y1_d;
      y2_q            <= y2_d;
    end
  end
endmodule

// File: tb/tb_biquad_sequencer.sv
// Self-checking bench for biquad_sequencer: a per-edge reference model of the
// sequencer's observable behaviour plus directed scenarios with literal results.
module tb_biquad_sequencer;
  localparam int CHANNELS = 3;
  localparam int FRAC     = 10;
  localparam int CH_W     = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  biquad_sequencer_if #(.CH_W(CH_W)) bus ();

  biquad_sequencer #(.CHANNELS(CHANNELS), .FRAC(FRAC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic signed [63:0] actual,
                       input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Reference model: n_edge is the index of the next rising edge; a sample accepted
  // at edge n keeps the sequencer busy until the cycle ending at edge n+7, in which
  // its result is presented.
  typedef struct {
    int     due;
    int     ch;
    longint sample;
    bit     sat;
  } exp_t;

  exp_t   expq[$];
  int     n_edge    = 0;
  int     idle_from = 0;
  bit     model_on  = 1'b0;
  bit     clr_pend  = 1'b0;
  longint m_sh [5];
  longint m_act[5];
  longint m_x1[CHANNELS];
  longint m_x2[CHANNELS];
  longint m_y1[CHANNELS];
  longint m_y2[CHANNELS];

  task automatic model_accept(input int ch, input longint s);
    exp_t   e;
    longint acc;
    longint res;
    m_act = m_sh;
    e.due = n_edge + 7;
    e.ch  = ch;
    e.sat = 1'b0;
    if (ch < CHANNELS) begin
      acc = m_act[0] * s + m_act[1] * m_x1[ch] + m_act[2] * m_x2[ch]
          + m_act[3] * m_y1[ch] + m_act[4] * m_y2[ch];
      res = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
      if (res > 32767) begin
        res = 32767;
        e.sat = 1'b1;
      end else if (res < -32768) begin
        res = -32768;
        e.sat = 1'b1;
      end
      m_x2[ch] = m_x1[ch];
      m_x1[ch] = s;
      m_y2[ch] = m_y1[ch];
      m_y1[ch] = res;
      e.sample = res;
    end else begin
      e.sample = 0;
    end
    expq.push_back(e);
    idle_from = n_edge + 7;
  endtask

  always @(negedge clk) begin
    bit idle;
    bit exp_valid;
    if (model_on) begin
      idle      = (n_edge >= idle_from);
      exp_valid = (expq.size() > 0) && (expq[0].due == n_edge);
      check("in_ready", bus.in_ready, idle && !clr_pend);
      check("busy", bus.busy, !idle);
      check("out_valid", bus.out_valid, exp_valid);
      check("out_sat", bus.out_sat, exp_valid ? expq[0].sat : 1'b0);
      if (exp_valid) begin
        check("out_sample", bus.out_sample, expq[0].sample);
        check("out_ch", bus.out_ch, expq[0].ch);
        void'(expq.pop_front());
      end
    end
    if (reset) begin
      model_on  = 1'b1;
      clr_pend  = 1'b0;
      idle_from = n_edge + 1;
      expq.delete();
      for (int i = 0; i < 5; i++) m_sh[i] = (i == 0) ? (64'sd1 <<< FRAC) : 0;
      m_act = m_sh;
      for (int c = 0; c < CHANNELS; c++) begin
        m_x1[c] = 0; m_x2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
      end
    end else if (model_on) begin
      idle = (n_edge >= idle_from);
      if (idle && clr_pend) begin
        for (int c = 0; c < CHANNELS; c++) begin
          m_x1[c] = 0; m_x2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
        end
        clr_pend = 1'b0;
      end else if (idle && bus.in_valid) begin
        model_accept(int'(bus.in_ch), longint'(bus.in_sample));
      end
      if (bus.cfg_we) begin
        if (bus.cfg_addr <= 3'd4) m_sh[bus.cfg_addr] = longint'(bus.cfg_data);
        if (bus.cfg_addr == 3'd7) clr_pend = 1'b1;
      end
    end
    n_edge++;
  end

  // Stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic send_sample(input int ch, input int s);
    int n;
    n = 0;
    bus.in_ch     = CH_W'(ch);
    bus.in_sample = 16'(s);
    bus.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("accept");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'(addr);
    bus.cfg_data = 32'(data);
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic load_biquad();
    cfg_write(0, 1015);
    cfg_write(1, 2030);
    cfg_write(2, 1015);
    cfg_write(3, 2030);
    cfg_write(4, -1006);
  endtask

  task automatic check_output(input string name, input int exp_sample, input bit exp_sat);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        check(name, bus.out_sample, exp_sample);
        check({name, "_sat"}, bus.out_sat, exp_sat);
      end
    end
    if (!seen) fail_now(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int cnt;
    bit seen;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_sample = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_out_sample", bus.out_sample, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] pass-through and latency");
    send_sample(0, 1000);
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (k == 3) check("ready_while_busy", bus.in_ready, 0);
      if (bus.out_valid) begin
        seen = 1'b1;
        lat  = k;
        check("passthru", bus.out_sample, 1000);
        check("passthru_sat", bus.out_sat, 0);
      end
    end
    check("latency", lat, 7);
    @(posedge clk);
    #1;

    $display("[TB] saturation");
    cfg_write(0, 2048);
    send_sample(0, 20000);
    check_output("sat_pos", 32767, 1'b1);
    send_sample(0, -20000);
    check_output("sat_neg", -32768, 1'b1);

    $display("[TB] impulse response");
    cfg_write(7, 0);
    load_biquad();
    send_sample(0, 1024);
    check_output("imp_0", 1015, 1'b0);
    send_sample(0, 0);
    check_output("imp_1", 4042, 1'b0);

    $display("[TB] channel interleave");
    cfg_write(7, 0);
    send_sample(0, 1024);
    check_output("il_ch0_0", 1015, 1'b0);
    send_sample(1, 0);
    check_output("il_ch1_0", 0, 1'b0);
    send_sample(0, 0);
    check_output("il_ch0_1", 4042, 1'b0);
    send_sample(1, 0);
    check_output("il_ch1_1", 0, 1'b0);

    $display("[TB] shadow coefficient update");
    cfg_write(0, 1024);
    cfg_write(1, 0);
    cfg_write(2, 0);
    cfg_write(3, 0);
    cfg_write(4, 0);
    send_sample(1, 500);
    cfg_write(0, 0);
    check_output("shadow_old", 500, 1'b0);
    send_sample(1, 700);
    check_output("shadow_new", 0, 1'b0);
    bus.in_ch     = 2'd1;
    bus.in_sample = 16'sd300;
    bus.in_valid  = 1'b1;
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3'd0;
    bus.cfg_data  = 32'sd1024;
    @(negedge clk);
    check("same_edge_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    check_output("same_edge_cfg", 0, 1'b0);
    send_sample(1, 300);
    check_output("after_same_edge", 300, 1'b0);

    $display("[TB] clear while busy");
    load_biquad();
    cfg_write(7, 0);
    send_sample(0, 1024);
    check_output("clr_pre_0", 1015, 1'b0);
    send_sample(0, 0);
    check_output("clr_pre_1", 4042, 1'b0);
    send_sample(0, 0);
    cfg_write(7, 0);
    send_sample(0, 1024);
    check_output("clr_restart", 1015, 1'b0);

    $display("[TB] out-of-range channel");
    send_sample(3, 5000);
    check_output("bad_ch", 0, 1'b0);
    send_sample(0, 0);
    check_output("bad_ch_state", 4042, 1'b0);

    $display("[TB] reset mid-sample");
    send_sample(1, 777);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("abort_no_out", cnt, 0);
    check("abort_out_sample", bus.out_sample, 0);
    check("abort_out_sat", bus.out_sat, 0);
    check("abort_out_ch", bus.out_ch, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send_sample(1, 123);
    check_output("post_reset", 123, 1'b0);

    repeat (3) @(posedge clk);
    check("drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
